ovr_arbiter: RTL and testbench
==============================

// Module: ovr_arbiter
// PURPOSE
//  Shares one override path on a W-bit signal between N_REQ requesters (procedural assign/deassign in RTL form).
//  Default: out_val follows func_val. A granted requester replaces it with its own latched value until it releases.
//  Round-robin arbitration. One override owner at a time. Optional hold timeout forces release.
//  Sits between the functional driver of a signal and its consumers (debug/test override fabric).
// PARAMETERS
//  N_REQ   4   number of requesters (>=2)
//  W       32  width of overridden signal
//  HOLD_W  8   width of hold-length counter
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          synchronous active-low reset
//  func_val   in   W          functional (non-override) value
//  req        in   N_REQ      override request, level, one bit per requester
//  ovr_val    in   N_REQ*W    override values; requester i on bits [i*W +: W]
//  hold_len   in   HOLD_W     max hold cycles (timeout build only; 0 = unlimited)
//  gnt        out  N_REQ      one-hot grant, registered
//  active     out  1          override in force, registered
//  owner      out  $clog2(N_REQ)  index of current/last owner, registered
//  out_val    out  W          active ? ovr_q : func_val (combinational mux)
//  timeout    out  1          1-cycle pulse on forced release (timeout build only; else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE, gnt=0, active=0, owner=0, rr_ptr=0, ovr_q=0, cnt=0, timeout=0.
//   out_val follows func_val during and after reset.
//  Reset mid-HOLD: the override drops the cycle after reset is sampled. No REL cycle.
//  FSM states: IDLE, HOLD, REL.
//  IDLE: out_val=func_val. If req!=0, pick winner k.
//   k = first set bit at or after rr_ptr, wrapping N_REQ-1 -> 0.
//   Next edge: gnt=1<<k, owner=k, active=1, ovr_q=ovr_val[k], cnt=hold_len, go to HOLD.
//   Latency: req seen at edge t -> gnt/active/out_val=override after edge t+1.
//  HOLD: out_val=ovr_q. ovr_val changes are ignored (value latched once at grant).
//   Other reqs are ignored. No preemption.
//   Release when req[owner]==0. Timeout build also releases on timeout (see CONFIGURATION).
//   Release action: go to REL, gnt=0, active=0.
//  REL: one cycle. out_val=func_val. rr_ptr=(owner+1) mod N_REQ. Then IDLE.
//   Guarantees at least 1 func_val cycle between owners.
//   A lone requester holding req is re-granted after IDLE (i.e. 2 cycles after release).
//  Simultaneous: req drop and timeout expiry in the same cycle -> normal release, timeout stays 0.
//  Requests in REL are not arbitrated until IDLE.
//  owner keeps its value after release.
// CONFIGURATION
//  Macro OVR_ARB_TIMEOUT_EN.
//  Defined: cnt (HOLD_W bits) loaded with hold_len at grant.
//   In HOLD, cnt decrements each cycle while cnt!=0. hold_len==0 disables the timeout.
//   When cnt reaches 1 and req[owner] is still 1: release (HOLD lasts exactly hold_len cycles) and pulse timeout for 1 cycle.
//   The evicted requester must deassert and reassert req to be considered fair. It is still eligible by rr order.
//  Undefined: no counter. hold_len unused. timeout tied 0. Release only on req drop.
// STRUCTURE
//  Package ovr_arb_pkg: state_e enum {IDLE, HOLD, REL}; function rr_first(req, ptr) helper.
//  Sub-module ovr_rr_pick: combinational round-robin picker, (req, rr_ptr) -> one-hot + index.
//  Top holds the FSM, grant/owner/ovr_q registers, counter and output mux.
// TESTING
//  1 Reset: rst_n=0 for 3 cycles, func_val=32'hA5A5_0001 -> gnt=0, active=0, out_val=32'hA5A5_0001.
//  2 Single grant: req=4'b0100, ovr_val[2]=32'hDEAD_BEEF -> next cycle gnt=4'b0100, owner=2, out_val=DEADBEEF.
//    Then drop req -> REL, out_val=func_val, rr_ptr=3.
//  3 Round robin: req=4'b1111 held, hold released by toggling each owner -> grant order 0,1,2,3,0.
//    1 func_val cycle between each owner.
//  4 Latch: during HOLD change ovr_val[owner] 32'h1 -> 32'h2 -> out_val stays 32'h1.
//    Other req bits asserted give no gnt change.
//  5 Timeout (OVR_ARB_TIMEOUT_EN, hold_len=5): req=4'b0001 held -> active for exactly 5 cycles, timeout pulses once.
//    REL, then re-grant to 0. With hold_len=0: no release for 100 cycles.
//  6 Reset mid-HOLD: owner=1 active, assert rst_n=0 -> next cycle gnt=0, active=0, out_val=func_val, rr_ptr=0.

Source files
------------

// File: rtl/ovr_arb_pkg.sv
// Shared types and helpers for the override arbiter: FSM state encoding
// and the round-robin first-set-bit search used by the picker.
package ovr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    REL  = 2'd2
  } state_e;

  // Widest request vector the helper accepts; callers zero-extend into it.
  localparam int unsigned RR_MAX_REQ = 32;

  // Index of the first set bit of req[n-1:0] at or after ptr, wrapping
  // n-1 -> 0. Returns ptr when no bit is set (caller qualifies with |req).
  function automatic int unsigned rr_first(
    input logic [RR_MAX_REQ-1:0] req,
    input int unsigned           ptr,
    input int unsigned           n
  );
    int unsigned idx;
    logic        found;
    rr_first = ptr;
    found    = 1'b0;
    for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && req[idx]) begin
        rr_first = idx;
        found    = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/ovr_arbiter_if.sv
// Signal bundle between override requesters/functional driver (master)
// and the override arbiter (slave).
interface ovr_arbiter_if #(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned W      = 32,
  parameter int unsigned HOLD_W = 8
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [W-1:0]       func_val;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] ovr_val;
  logic [HOLD_W-1:0]  hold_len;

  logic [N_REQ-1:0]   gnt;
  logic               active;
  logic [IDX_W-1:0]   owner;
  logic [W-1:0]       out_val;
  logic               timeout;

  modport master (
    output func_val, req, ovr_val, hold_len,
    input  gnt, active, owner, out_val, timeout
  );

  modport slave (
    input  func_val, req, ovr_val, hold_len,
    output gnt, active, owner, out_val, timeout
  );

endinterface

// File: rtl/ovr_rr_pick.sv
// Combinational round-robin picker: first requester at or after the
// pointer, returned both one-hot and as an index.
module ovr_rr_pick
  import ovr_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_onehot,
  output logic [$clog2(N_REQ)-1:0] o_idx,
  output logic                     o_valid
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  logic [RR_MAX_REQ-1:0] w_req_ext;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_valid;

  always_comb begin
    w_req_ext              = '0;
    w_req_ext[N_REQ-1:0]   = i_req;
    w_idx                  = IDX_W'(rr_first(w_req_ext, 32'(i_ptr), N_REQ));
    w_valid                = |i_req;
  end

  assign o_idx    = w_idx;
  assign o_valid  = w_valid;
  assign o_onehot = w_valid ? (N_REQ'(1) << w_idx) : '0;

endmodule

// File: rtl/ovr_arbiter.sv
// Round-robin owner of a single override path on a W-bit signal.
// Optional hold timeout is compiled in with `define OVR_ARB_TIMEOUT_EN.
module ovr_arbiter
  import ovr_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned W      = 32,
  parameter int unsigned HOLD_W = 8
) (
  input logic          clk,
  input logic          rst_n,
  ovr_arbiter_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(N_REQ);

  state_e           r_state;
  state_e           w_state_nxt;

  logic [N_REQ-1:0] r_gnt,    w_gnt_nxt;
  logic             r_active, w_active_nxt;
  logic [IDX_W-1:0] r_owner,  w_owner_nxt;
  logic [IDX_W-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [W-1:0]     r_ovr_q,  w_ovr_q_nxt;

  logic [N_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic [W-1:0]     w_ovr_arr [N_REQ];
  logic             w_owner_req;
  logic             w_expire;
  logic             w_release;

  ovr_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req    (bus.req),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      w_ovr_arr[i] = bus.ovr_val[i*W +: W];
    end
  end

  assign w_owner_req = bus.req[r_owner];
  // A req drop wins over expiry, so the timeout pulse only marks true evictions.
  assign w_release   = (r_state == HOLD) && (!w_owner_req || w_expire);

`ifdef OVR_ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] r_cnt;
  logic              r_timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_release && w_owner_req;
      if ((r_state == IDLE) && w_pick_valid) begin
        r_cnt <= bus.hold_len;
      end else if ((r_state == HOLD) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign w_expire    = (r_cnt == HOLD_W'(1));
  assign bus.timeout = r_timeout;
`else
  logic w_unused_hold_len;
  assign w_unused_hold_len = ^bus.hold_len;
  assign w_expire          = 1'b0;
  assign bus.timeout       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_pick_valid) w_state_nxt = HOLD;
      HOLD:    if (w_release)    w_state_nxt = REL;
      REL:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt    = r_gnt;
    w_active_nxt = r_active;
    w_owner_nxt  = r_owner;
    w_rr_ptr_nxt = r_rr_ptr;
    w_ovr_q_nxt  = r_ovr_q;
    unique case (r_state)
      IDLE: begin
        if (w_pick_valid) begin
          w_gnt_nxt    = w_pick_onehot;
          w_active_nxt = 1'b1;
          w_owner_nxt  = w_pick_idx;
          w_ovr_q_nxt  = w_ovr_arr[w_pick_idx];
        end
      end
      HOLD: begin
        if (w_release) begin
          w_gnt_nxt    = '0;
          w_active_nxt = 1'b0;
        end
      end
      REL: begin
        w_rr_ptr_nxt = (r_owner == IDX_W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_gnt    <= '0;
      r_active <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_ovr_q  <= '0;
    end else begin
      r_gnt    <= w_gnt_nxt;
      r_active <= w_active_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
      r_ovr_q  <= w_ovr_q_nxt;
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.active  = r_active;
  assign bus.owner   = r_owner;
  assign bus.out_val = r_active ? r_ovr_q : bus.func_val;

endmodule

// File: tb/tb_ovr_arbiter.sv
// Self-checking bench for ovr_arbiter: directed scenarios then random
// traffic, all compared against a cycle-level behavioural model.
module tb_ovr_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned W  = 32;
  localparam int unsigned HW = 8;
`ifdef OVR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ovr_arbiter_if #(.N_REQ(N), .W(W), .HOLD_W(HW)) bus ();

  ovr_arbiter #(.N_REQ(N), .W(W), .HOLD_W(HW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_err = 0;
  int n_chk = 0;

  // Model: is an owner holding, is this the mandatory gap cycle, etc.
  bit           m_busy, m_gap, m_to;
  int           m_owner, m_ptr, m_cnt;
  logic [W-1:0] m_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int j = 0; j < N; j++) begin
      if (r[(ptr + j) % N]) return (ptr + j) % N;
    end
    return 0;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_busy = 0; m_gap = 0; m_to = 0;
      m_owner = 0; m_ptr = 0; m_cnt = 0; m_val = '0;
    end else begin
      m_to = 0;
      if (m_busy) begin
        if (!bus.req[m_owner]) begin
          m_busy = 0; m_gap = 1;
        end else if (TO_EN && m_cnt == 1) begin
          m_busy = 0; m_gap = 1; m_to = 1;
        end else if (m_cnt > 0) begin
          m_cnt--;
        end
      end else if (m_gap) begin
        m_gap = 0;
        m_ptr = (m_owner + 1) % N;
      end else if (bus.req != '0) begin
        m_owner = pick(bus.req, m_ptr);
        m_busy  = 1;
        m_val   = bus.ovr_val[m_owner*W +: W];
        m_cnt   = int'(bus.hold_len);
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check("gnt",     32'(bus.gnt),     m_busy ? (32'd1 << m_owner) : 32'd0);
    check("active",  32'(bus.active),  32'(m_busy));
    check("owner",   32'(bus.owner),   32'(m_owner));
    check("out_val", bus.out_val,      m_busy ? m_val : bus.func_val);
    check("timeout", 32'(bus.timeout), 32'(m_to));
  endtask

  task automatic set_ovr(input int i, input logic [W-1:0] v);
    bus.ovr_val[i*W +: W] = v;
  endtask

  task automatic wait_active(input string tag);
    for (int c = 0; c < 8 && bus.active !== 1'b1; c++) tick();
    check(tag, 32'(bus.active), 32'd1);
  endtask

  int exp_order [5] = '{0, 1, 2, 3, 0};
  int n_act, n_pulse, n_idle;

  initial begin
    // Reset
    rst_n = 1'b0;
    bus.req = '0; bus.ovr_val = '0; bus.hold_len = '0;
    bus.func_val = 32'hA5A5_0001;
    repeat (3) tick();
    check("rst_out",    bus.out_val,      32'hA5A5_0001);
    check("rst_gnt",    32'(bus.gnt),     32'd0);
    check("rst_active", 32'(bus.active),  32'd0);
    rst_n = 1'b1;

    // Single grant, release, pointer moves to 3
    set_ovr(2, 32'hDEAD_BEEF);
    bus.req = 4'b0100;
    tick();
    check("t2_gnt",   32'(bus.gnt),   32'h4);
    check("t2_owner", 32'(bus.owner), 32'd2);
    check("t2_out",   bus.out_val,    32'hDEAD_BEEF);
    repeat (2) tick();
    bus.req = '0;
    tick();
    check("t2_rel_out", bus.out_val, 32'hA5A5_0001);
    check("t2_rel_act", 32'(bus.active), 32'd0);
    tick();
    bus.req = 4'b1111;
    tick();
    check("t2_ptr_owner", 32'(bus.owner), 32'd3);
    bus.req = '0;
    repeat (2) tick();

    // Round robin with all requesters held
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_ovr(i, 32'hC0DE_0000 + 32'(i));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      bus.func_val = 32'h1234_0000 + 32'(k);
      wait_active("t3_grant");
      check("t3_order", 32'(bus.owner), 32'(exp_order[k]));
      check("t3_val",   bus.out_val, 32'hC0DE_0000 + 32'(exp_order[k]));
      bus.req[bus.owner] = 1'b0;
      tick();
      check("t3_gap", bus.out_val, 32'h1234_0000 + 32'(k));
      bus.req = 4'b1111;
    end
    bus.req = '0;
    repeat (3) tick();

    // Latched value and no preemption
    set_ovr(1, 32'h1);
    bus.req = 4'b0010;
    wait_active("t4_grant");
    set_ovr(1, 32'h2);
    bus.req = 4'b1111;
    repeat (4) tick();
    check("t4_latch", bus.out_val, 32'h1);
    check("t4_gnt",   32'(bus.gnt), 32'h2);
    bus.req = '0;
    repeat (3) tick();

`ifdef OVR_ARB_TIMEOUT_EN
    // Hold timeout of 5 cycles with the request held throughout
    bus.hold_len = 8'd5;
    bus.req = 4'b0001;
    wait_active("t5_grant");
    n_act = 1; n_pulse = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.timeout === 1'b1) n_pulse++;
      if (bus.active !== 1'b1) break;
      n_act++;
    end
    check("t5_len",   32'(n_act),   32'd5);
    check("t5_pulse", 32'(n_pulse), 32'd1);
    wait_active("t5_regrant");
    check("t5_reowner", 32'(bus.owner), 32'd0);
    bus.req = '0;
    repeat (3) tick();
`else
    // Without the timeout build a long hold_len never forces release
    bus.hold_len = 8'd5;
    bus.req = 4'b0001;
    wait_active("t5_grant");
    n_idle = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (bus.active !== 1'b1) n_idle++;
    end
    check("t5_nohold", 32'(n_idle), 32'd0);
    bus.req = '0;
    repeat (3) tick();
`endif

    // hold_len = 0 means unlimited in every build
    bus.hold_len = '0;
    bus.req = 4'b0001;
    wait_active("t5z_grant");
    n_idle = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.active !== 1'b1) n_idle++;
    end
    check("t5z_unlim", 32'(n_idle), 32'd0);
    bus.req = '0;
    repeat (3) tick();

    // Reset while owner 1 holds
    bus.func_val = 32'h5555_AAAA;
    bus.req = 4'b0010;
    wait_active("t6_grant");
    check("t6_owner", 32'(bus.owner), 32'd1);
    rst_n = 1'b0;
    tick();
    check("t6_gnt", 32'(bus.gnt),    32'd0);
    check("t6_act", 32'(bus.active), 32'd0);
    check("t6_out", bus.out_val,     32'h5555_AAAA);
    rst_n = 1'b1;
    bus.req = 4'b1111;
    tick();
    check("t6_ptr", 32'(bus.owner), 32'd0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      bus.func_val = $urandom;
      for (int i = 0; i < N; i++) set_ovr(i, $urandom);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      if ($urandom_range(0, 15) == 0) bus.hold_len = 8'($urandom_range(0, 6));
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
